latch_bank_ctrl: RTL and testbench

Controller that shares a bank of NLAT level-sensitive data latches (d/clock/clear latch primitives) among NREQ requesters. A round-robin arbiter picks one pending write. A four-phase FSM drives the shared latch data bus and the one-hot latch gates with guaranteed setup and hold around each gate pulse. The block sits between the requesting logic and the latch bank and is the only driver of the bank's d, clock and clear pins.

---
 rtl/latch_bank_ctrl_pkg.sv | 8 +
 rtl/latch_bank_ctrl_if.sv | 34 +++
 rtl/latch_bank_ctrl_arb.sv | 29 ++
 rtl/latch_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_latch_bank_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/latch_bank_ctrl_pkg.sv
// latch_bank_ctrl_pkg: shared FSM state type and default sizing for latch bank controllers.
package latch_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLEAR} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_NLAT = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_OPEN_CYC = 2;
endpackage

// File: rtl/latch_bank_ctrl_if.sv
// latch_bank_ctrl_if: requester and latch-bank signals; clr_req/clr_done exist only with LATCH_CLEAR_EN.
interface latch_bank_ctrl_if #(
  parameter int NREQ = latch_ctrl_pkg::DEF_NREQ,
  parameter int NLAT = latch_ctrl_pkg::DEF_NLAT,
  parameter int DW = latch_ctrl_pkg::DEF_DW,
  parameter int AW = $clog2(NLAT)
);
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0] ack;
  logic [DW-1:0] lat_d;
  logic [NLAT-1:0] lat_gate;
  logic lat_clear;
  logic busy;
`ifdef LATCH_CLEAR_EN
  logic clr_req;
  logic clr_done;
`endif
  modport master (
`ifdef LATCH_CLEAR_EN
    output clr_req, input clr_done,
`endif
    output req, addr, data,
    input ack, lat_d, lat_gate, lat_clear, busy
  );
  modport slave (
`ifdef LATCH_CLEAR_EN
    input clr_req, output clr_done,
`endif
    input req, addr, data,
    output ack, lat_d, lat_gate, lat_clear, busy
  );
endinterface

// File: rtl/latch_bank_ctrl_arb.sv
// rr_arbiter: combinational round-robin pick starting one past ptr; one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);
  logic [IW-1:0] j;
  logic hit;
  // scan from farthest to nearest so the nearest pending requester wins
  always_comb begin
    idx = '0;
    hit = 1'b0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (en && req[j]) begin
        idx = j;
        hit = 1'b1;
      end
    end
    gnt = hit ? ONE << idx : '0;
  end
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin shared write controller for a bank of level-sensitive latches.
// Optional bank clear sequence enabled by defining LATCH_CLEAR_EN.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int NLAT = DEF_NLAT,
  parameter int DW = DEF_DW,
  parameter int AW = $clog2(NLAT),
  parameter int OPEN_CYC = DEF_OPEN_CYC
) (
  input logic CLK,
  input logic RESET,
  latch_bank_ctrl_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(OPEN_CYC + 1);
  localparam logic [NLAT-1:0] ONE_LAT = NLAT'(1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, arb_idx;
  logic [NREQ-1:0] arb_gnt, ggnt, ack;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] lat_d;
  logic [NLAT-1:0] lat_gate;
  logic lat_clear, busy, arb_en;
`ifdef LATCH_CLEAR_EN
  logic clr_done;
  assign arb_en = (state == IDLE) && !bus.clr_req;
  assign bus.clr_done = clr_done;
`else
  assign arb_en = (state == IDLE);
`endif
  rr_arbiter #(.N(NREQ)) u_arb (
    .req(bus.req),
    .en(arb_en),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  // addresses beyond the bank shift the gate bit out, so the sequence runs with no gate
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= IW'(NREQ - 1);
      ggnt <= '0;
      gaddr <= '0;
      lat_d <= '0;
      lat_gate <= '0;
      ack <= '0;
      lat_clear <= 1'b1;
      busy <= 1'b0;
`ifdef LATCH_CLEAR_EN
      clr_done <= 1'b0;
`endif
    end else begin
      ack <= '0;
      lat_clear <= 1'b0;
`ifdef LATCH_CLEAR_EN
      clr_done <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef LATCH_CLEAR_EN
          if (bus.clr_req) begin
            state <= CLEAR;
            lat_clear <= 1'b1;
            cnt <= CW'(OPEN_CYC - 1);
            busy <= 1'b1;
          end else
`endif
          if (|arb_gnt) begin
            state <= SETUP;
            busy <= 1'b1;
            ptr <= arb_idx;
            ggnt <= arb_gnt;
            gaddr <= bus.addr[arb_idx*AW +: AW];
            lat_d <= bus.data[arb_idx*DW +: DW];
          end
        end
        SETUP: begin
          state <= OPEN;
          lat_gate <= ONE_LAT << gaddr;
          cnt <= CW'(OPEN_CYC - 1);
        end
        OPEN: begin
          if (cnt == '0) begin
            state <= HOLD;
            lat_gate <= '0;
            ack <= ggnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state <= IDLE;
          busy <= 1'b0;
        end
`ifdef LATCH_CLEAR_EN
        CLEAR: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            lat_clear <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ack = ack;
  assign bus.lat_d = lat_d;
  assign bus.lat_gate = lat_gate;
  assign bus.lat_clear = lat_clear;
  assign bus.busy = busy;
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: directed scenarios plus randomized traffic against a transaction-level timing model.
module tb_latch_bank_ctrl;
  localparam int NREQ = 4, NLAT = 4, DW = 8, AW = 3, OC = 2;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  latch_bank_ctrl_if #(.NREQ(NREQ), .NLAT(NLAT), .DW(DW), .AW(AW)) bus ();
  latch_bank_ctrl #(.NREQ(NREQ), .NLAT(NLAT), .DW(DW), .AW(AW), .OPEN_CYC(OC)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
    bus.req[i] = 1'b1;
    bus.addr[i*AW +: AW] = AW'(a);
    bus.data[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    n_checks++; if (bus.lat_clear !== 1'b1) begin n_fail++; $display("FAIL reset_clear: got %b expected 1", bus.lat_clear); end
    n_checks++; if ({bus.ack, bus.lat_gate, bus.lat_d, bus.busy} !== '0) begin n_fail++; $display("FAIL reset_outputs: ack=%b gate=%b d=%h busy=%b expected all 0", bus.ack, bus.lat_gate, bus.lat_d, bus.busy); end
    RESET = 1'b1;
    #1;
    n_checks++; if (bus.lat_clear !== 1'b1) begin n_fail++; $display("FAIL release_clear_hold: got %b expected 1", bus.lat_clear); end
    @(negedge CLK);
    n_checks++; if (bus.lat_clear !== 1'b0) begin n_fail++; $display("FAIL release_clear_drop: got %b expected 0", bus.lat_clear); end
    n_checks++; if ({bus.ack, bus.lat_gate, bus.busy} !== '0) begin n_fail++; $display("FAIL release_outputs: ack=%b gate=%b busy=%b expected 0", bus.ack, bus.lat_gate, bus.busy); end
  endtask

  task automatic test_single_write();
    logic [NLAT-1:0] eg;
    logic [NREQ-1:0] ea;
    set_req(1, 2, 8'hA5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      eg = (c >= 2 && c <= 1 + OC) ? 4'b0100 : 4'b0000;
      ea = (c == 2 + OC) ? 4'b0010 : 4'b0000;
      n_checks++; if (bus.lat_gate !== eg) begin n_fail++; $display("FAIL single_gate c%0d: got %b expected %b", c, bus.lat_gate, eg); end
      n_checks++; if (bus.ack !== ea) begin n_fail++; $display("FAIL single_ack c%0d: got %b expected %b", c, bus.ack, ea); end
      n_checks++; if (bus.lat_d !== 8'hA5) begin n_fail++; $display("FAIL single_latd c%0d: got %h expected a5", c, bus.lat_d); end
      n_checks++; if (bus.busy !== (c <= 2 + OC)) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, bus.busy, c <= 2 + OC); end
      if (c == 1) bus.data[1*DW +: DW] = 8'h5A;
      if (c == 2 + OC) bus.req[1] = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int cyc = 0, n = 0, prev = 0, g;
    int order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i, DW'(8'h10 + i));
    while (n < 5 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (bus.ack != '0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (bus.ack[i]) g = i;
        n_checks++; if ($countones(bus.ack) != 1 || g != order[n]) begin n_fail++; $display("FAIL rr_order #%0d: got %b expected requester %0d", n, bus.ack, order[n]); end
        n_checks++; if (cyc - prev != (n == 0 ? 2 + OC : 3 + OC)) begin n_fail++; $display("FAIL rr_spacing #%0d: got %0d expected %0d", n, cyc - prev, n == 0 ? 2 + OC : 3 + OC); end
        prev = cyc;
        n++;
      end
    end
    bus.req = '0;
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL rr_timeout: got %0d acks expected 5", n); end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_bad_addr();
    logic [NREQ-1:0] ea;
    set_req(3, 5, 8'hC3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      ea = (c == 2 + OC) ? 4'b1000 : 4'b0000;
      n_checks++; if (bus.lat_gate !== '0) begin n_fail++; $display("FAIL badaddr_gate c%0d: got %b expected 0000", c, bus.lat_gate); end
      n_checks++; if (bus.ack !== ea) begin n_fail++; $display("FAIL badaddr_ack c%0d: got %b expected %b", c, bus.ack, ea); end
      if (c == 2 + OC) bus.req[3] = 1'b0;
    end
  endtask

  task automatic test_req_drop();
    logic [NLAT-1:0] eg;
    logic [NREQ-1:0] ea;
    set_req(0, 1, 8'h77);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) bus.req[0] = 1'b0;
      eg = (c >= 2 && c <= 1 + OC) ? 4'b0010 : 4'b0000;
      ea = (c == 2 + OC) ? 4'b0001 : 4'b0000;
      n_checks++; if (bus.lat_gate !== eg) begin n_fail++; $display("FAIL drop_gate c%0d: got %b expected %b", c, bus.lat_gate, eg); end
      n_checks++; if (bus.ack !== ea) begin n_fail++; $display("FAIL drop_ack c%0d: got %b expected %b", c, bus.ack, ea); end
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    set_req(1, 0, 8'h11);
    set_req(3, 3, 8'h33);
    do begin @(negedge CLK); w++; end while (bus.lat_gate == '0 && w < 10);
    n_checks++; if (bus.lat_gate == '0) begin n_fail++; $display("FAIL midrst_open_timeout: gate=%b expected nonzero within 10 cycles", bus.lat_gate); end
    RESET = 1'b0;
    #1;
    n_checks++; if (bus.lat_gate !== '0 || bus.lat_clear !== 1'b1) begin n_fail++; $display("FAIL midrst_async: gate=%b clear=%b expected 0000/1", bus.lat_gate, bus.lat_clear); end
    repeat (2) begin
      @(negedge CLK);
      n_checks++; if (bus.ack !== '0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_noack: ack=%b busy=%b expected 0", bus.ack, bus.busy); end
    end
    RESET = 1'b1;
    for (int c = 1; c <= 2 + OC; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        n_checks++; if (bus.lat_clear !== 1'b0 || bus.busy !== 1'b1 || bus.lat_d !== 8'h11) begin n_fail++; $display("FAIL midrst_regrant: clear=%b busy=%b d=%h expected 0/1/11", bus.lat_clear, bus.busy, bus.lat_d); end
      end
    end
    n_checks++; if (bus.ack !== 4'b0010) begin n_fail++; $display("FAIL midrst_ack: got %b expected 0010", bus.ack); end
    bus.req = '0;
    repeat (2) @(negedge CLK);
  endtask

`ifdef LATCH_CLEAR_EN
  task automatic test_clear();
    logic [NLAT-1:0] eg;
    logic [NREQ-1:0] ea;
    apply_reset();
    bus.clr_req = 1'b1;
    set_req(2, 1, 8'h3C);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      bus.clr_req = 1'b0;
      eg = (c >= 5 && c <= 4 + OC) ? 4'b0010 : 4'b0000;
      ea = (c == 5 + OC) ? 4'b0100 : 4'b0000;
      n_checks++; if (bus.lat_clear !== (c <= OC)) begin n_fail++; $display("FAIL clr_clear c%0d: got %b expected %b", c, bus.lat_clear, c <= OC); end
      n_checks++; if (bus.clr_done !== (c == OC + 1)) begin n_fail++; $display("FAIL clr_done c%0d: got %b expected %b", c, bus.clr_done, c == OC + 1); end
      n_checks++; if (bus.lat_gate !== eg || bus.ack !== ea) begin n_fail++; $display("FAIL clr_write c%0d: gate=%b ack=%b expected %b/%b", c, bus.lat_gate, bus.ack, eg, ea); end
      if (c == 5 + OC) bus.req[2] = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    bit m_active = 0;
    int m_t = 0, m_g = 0, m_last = NREQ - 1, m_addr = 0;
    logic [DW-1:0] m_latd = '0;
    logic [NLAT-1:0] eg;
    logic [NREQ-1:0] ea;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      eg = (m_active && m_t >= 2 && m_t <= OC + 1 && m_addr < NLAT) ? NLAT'(1) << m_addr : '0;
      ea = (m_active && m_t == OC + 2) ? NREQ'(1) << m_g : '0;
      n_checks++; if (bus.lat_gate !== eg) begin n_fail++; $display("FAIL rand_gate cyc%0d: got %b expected %b", cyc, bus.lat_gate, eg); end
      n_checks++; if (bus.ack !== ea) begin n_fail++; $display("FAIL rand_ack cyc%0d: got %b expected %b", cyc, bus.ack, ea); end
      n_checks++; if (bus.lat_d !== m_latd) begin n_fail++; $display("FAIL rand_latd cyc%0d: got %h expected %h", cyc, bus.lat_d, m_latd); end
      n_checks++; if (bus.busy !== m_active) begin n_fail++; $display("FAIL rand_busy cyc%0d: got %b expected %b", cyc, bus.busy, m_active); end
      for (int i = 0; i < NREQ; i++) begin
        if (ea[i]) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 3) == 0) set_req(i, $urandom_range(0, 7), DW'($urandom));
        else if (bus.req[i] && $urandom_range(0, 7) == 0) bus.data[i*DW +: DW] = DW'($urandom);
      end
      @(posedge CLK);
      if (m_active) begin
        if (m_t == OC + 2) m_active = 0;
        else m_t++;
      end else if (bus.req != '0) begin
        for (int k = 1; k <= NREQ; k++) if (bus.req[(m_last + k) % NREQ]) begin m_g = (m_last + k) % NREQ; break; end
        m_last = m_g;
        m_active = 1;
        m_t = 1;
        m_addr = int'(bus.addr[m_g*AW +: AW]);
        m_latd = bus.data[m_g*DW +: DW];
      end
      @(negedge CLK);
    end
    bus.req = '0;
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    bus.req = '0;
    bus.addr = '0;
    bus.data = '0;
`ifdef LATCH_CLEAR_EN
    bus.clr_req = 1'b0;
`endif
    test_reset();
    test_single_write();
    test_round_robin();
    test_bad_addr();
    test_req_drop();
    test_reset_mid();
`ifdef LATCH_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
